phys_bus_router: RTL and testbench

Physical-address bus responder for the CPU data port. It accepts one request at a time, already translated to a physical address, and decodes the address to on-chip RAM, the MMIO window, or unmapped space. It drives the selected device's handshake, waiting a fixed latency for RAM and up to a bounded timeout for MMIO. It then returns a single-cycle response carrying data or an error flag. It sits between the address-mapping stage and the RAM / peripheral interconnect.

---
 rtl/phys_bus_pkg.sv | 20 ++
 rtl/phys_region_decode.sv | 25 ++
 rtl/phys_bus_router.sv | 144 ++++++++++++++
 tb/tb_phys_bus_router.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_bus_pkg.sv
// Shared types and constants for the physical-address bus router and its decoder.
package phys_bus_pkg;

  localparam logic [15:0] IO_BASE_HI = 16'h1FAF;
  localparam logic [31:0] ERR_RDATA  = 32'h0;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_UNMAPPED
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StRamWait,
    StIoWait,
    StResp
  } state_e;

endpackage

// File: rtl/phys_region_decode.sv
// Combinational physical-address region decoder: RAM, MMIO window or unmapped.
module phys_region_decode
  import phys_bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 16
) (
  input  logic [31:0] addr,
  output logic [1:0]  region
);

  logic in_ram;

  // Everything above the RAM byte range must be zero.
  assign in_ram = (addr >> (RAM_AW + 2)) == 32'h0;

  always_comb begin
    region = REG_UNMAPPED;
    if (in_ram) begin
      region = REG_RAM;
    end else if (addr[31:16] == IO_BASE_HI) begin
      region = REG_IO;
    end
  end

endmodule

// File: rtl/phys_bus_router.sv
// Single-outstanding CPU data-port responder routing to on-chip RAM or the MMIO window,
// with fixed RAM latency, bounded MMIO wait and a one-cycle response pulse.
module phys_bus_router
  import phys_bus_pkg::*;
#(
  parameter int unsigned RAM_AW     = 16,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [3:0]        io_be,
  output logic [15:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic              io_ack,
  input  logic [31:0]       io_rdata
);

  localparam int unsigned CntMax = (RAM_LAT > IO_TIMEOUT) ? RAM_LAT : IO_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RamLast = CntW'(RAM_LAT - 1);
  localparam logic [CntW-1:0] IoLast  = CntW'(IO_TIMEOUT - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [1:0]      region;

  phys_region_decode #(
    .RAM_AW(RAM_AW)
  ) u_decode (
    .addr  (cpu_addr),
    .region(region)
  );

  assign cpu_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      io_req     <= 1'b0;
      io_we      <= 1'b0;
      io_be      <= '0;
      io_addr    <= '0;
      io_wdata   <= '0;
    end else begin
      // RAM strobes and the response are single-cycle pulses.
      ram_en     <= 1'b0;
      ram_we     <= '0;
      cpu_rvalid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            cnt_q <= '0;
            we_q  <= cpu_we;
            case (region)
              REG_RAM: begin
                state_q   <= StRamWait;
                ram_en    <= 1'b1;
                ram_we    <= cpu_we ? cpu_be : 4'h0;
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= cpu_wdata;
              end
              REG_IO: begin
                state_q  <= StIoWait;
                io_req   <= 1'b1;
                io_we    <= cpu_we;
                io_be    <= cpu_be;
                io_addr  <= cpu_addr[15:0];
                io_wdata <= cpu_wdata;
              end
              default: begin
                state_q    <= StResp;
                cpu_rvalid <= 1'b1;
                cpu_err    <= 1'b1;
                cpu_rdata  <= ERR_RDATA;
              end
            endcase
          end
        end
        StRamWait: begin
          if (cnt_q == RamLast) begin
            state_q    <= StResp;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b0;
            cpu_rdata  <= we_q ? 32'h0 : ram_rdata;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIoWait: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (io_ack) begin
            state_q    <= StResp;
            io_req     <= 1'b0;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b0;
            cpu_rdata  <= we_q ? 32'h0 : io_rdata;
          end else if (cnt_q == IoLast) begin
            state_q    <= StResp;
            io_req     <= 1'b0;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b1;
            cpu_rdata  <= ERR_RDATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          cpu_err   <= 1'b0;
          cpu_rdata <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_phys_bus_router.sv
// Self-checking bench for phys_bus_router: vector table, hand sequences and random traffic
// compared against a transaction-level reference model.
module tb_phys_bus_router;

  localparam int AW    = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int TO    = 4;
  localparam logic [31:0] RamBytes = 32'h0004_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] io_val;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          en_cnt;
    int          req_cnt;
    int          ready_bad;
    int          io_unstable;
    logic [15:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [15:0] io_addr;
    logic        io_we;
    logic [3:0]  io_be;
    logic [31:0] io_wdata;
    logic        post_ready;
    logic        post_rvalid;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: RAM_LAT = 1, IO_TIMEOUT = 4
  logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid, cpu_err;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_req, io_we, io_ack;
  logic [3:0]  io_be;
  logic [15:0] io_addr;
  logic [31:0] io_wdata, io_rdata;

  // DUT B: RAM_LAT = 3
  logic        b_req, b_we, b_ready, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_ram_en;
  logic [3:0]  b_ram_we;
  logic [15:0] b_ram_addr;
  logic [31:0] b_ram_wdata, b_ram_rdata;
  logic        b_io_req, b_io_we;
  logic [3:0]  b_io_be;
  logic [15:0] b_io_addr;
  logic [31:0] b_io_wdata;

  phys_bus_router #(.RAM_AW(AW), .RAM_LAT(LAT_A), .IO_TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_be(io_be), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );

  phys_bus_router #(.RAM_AW(AW), .RAM_LAT(LAT_B), .IO_TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_req), .cpu_we(b_we), .cpu_be(b_be), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_ready(b_ready), .cpu_rvalid(b_rvalid),
    .cpu_rdata(b_rdata), .cpu_err(b_err),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata),
    .io_req(b_io_req), .io_we(b_io_we), .io_be(b_io_be), .io_addr(b_io_addr),
    .io_wdata(b_io_wdata), .io_ack(1'b0), .io_rdata(32'h0)
  );

  assign b_ram_rdata = {16'hB0B0, b_ram_addr};

  // RAM device for DUT A: 256 words, combinational read of the held address
  logic        mem_clr;
  logic [31:0] mem [0:255];
  assign ram_rdata = mem[ram_addr[7:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // MMIO device: acks in the ack_at-th cycle of io_req (0 = never)
  int          ack_at;
  int          io_cyc;
  logic [31:0] io_val;
  logic        late_ack;
  always @(posedge clk) io_cyc <= io_req ? io_cyc + 1 : 0;
  assign io_ack   = (io_req && ack_at != 0 && (io_cyc + 1) == ack_at) || late_ack;
  assign io_rdata = io_val;

  // Reference RAM contents, indexed by word address
  logic [31:0] ram_model [int];
  int n_checks = 0;
  int n_fail   = 0;
  int cur_txn  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %h, expected %h", name, cur_txn, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_read(input int w);
    return ram_model.exists(w) ? ram_model[w] : 32'h0;
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input int ack, input logic [31:0] iov,
                              input int lat, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.addr = addr; v.we = we; v.be = be; v.wdata = wdata; v.ack_at = ack; v.io_val = iov;
    v.lat = lat; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // Expected response from the address map, device latencies and RAM contents.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.addr < RamBytes) begin
      r.lat = LAT_A + 1; r.err = 1'b0;
      r.rdata = v.we ? 32'h0 : ram_read(int'(v.addr >> 2));
    end else if (v.addr[31:16] == 16'h1FAF) begin
      if (v.ack_at >= 1 && v.ack_at <= TO) begin
        r.lat = v.ack_at + 1; r.err = 1'b0; r.rdata = v.we ? 32'h0 : v.io_val;
      end else begin
        r.lat = TO + 1; r.err = 1'b1; r.rdata = 32'h0;
      end
    end else begin
      r.lat = 1; r.err = 1'b1; r.rdata = 32'h0;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, output obs_t o);
    int  guard = 0;
    bit  done  = 0;
    o = '0;
    o.lat = -1;
    ack_at = v.ack_at;
    io_val = v.io_val;
    @(negedge clk);
    while (!cpu_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cpu_req = 1'b1; cpu_we = v.we; cpu_be = v.be; cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(posedge clk);
    for (int n = 1; n <= 12 && !done; n++) begin
      @(negedge clk);
      if (n == 1) cpu_req = 1'b0;
      if (cpu_ready) o.ready_bad++;
      if (ram_en) begin
        o.en_cnt++;
        o.ram_addr = ram_addr; o.ram_we = ram_we; o.ram_wdata = ram_wdata;
      end
      if (io_req) begin
        if (o.req_cnt > 0 &&
            {io_we, io_be, io_addr, io_wdata} != {o.io_we, o.io_be, o.io_addr, o.io_wdata})
          o.io_unstable++;
        o.req_cnt++;
        o.io_we = io_we; o.io_be = io_be; o.io_addr = io_addr; o.io_wdata = io_wdata;
      end
      if (cpu_rvalid) begin
        o.lat = n; o.rdata = cpu_rdata; o.err = cpu_err;
        done = 1;
      end
    end
    @(negedge clk);
    o.post_ready  = cpu_ready;
    o.post_rvalid = cpu_rvalid;
  endtask

  task automatic check_txn(input vec_t v, input obs_t o);
    bit is_ram = v.addr < RamBytes;
    bit is_io  = !is_ram && v.addr[31:16] == 16'h1FAF;
    int exp_req = !is_io ? 0 : (v.ack_at >= 1 && v.ack_at <= TO) ? v.ack_at : TO;
    chk("rvalid latency", o.lat, v.lat);
    chk("err", {31'h0, o.err}, {31'h0, v.err});
    chk("rdata", o.rdata, v.rdata);
    chk("ram_en cycles", o.en_cnt, is_ram ? 1 : 0);
    chk("io_req cycles", o.req_cnt, exp_req);
    chk("ready low while busy", o.ready_bad, 0);
    chk("ready after resp", {31'h0, o.post_ready}, 32'h1);
    chk("rvalid single pulse", {31'h0, o.post_rvalid}, 32'h0);
    if (is_ram && o.en_cnt > 0) begin
      chk("ram_addr", {16'h0, o.ram_addr}, {16'h0, v.addr[17:2]});
      chk("ram_we", {28'h0, o.ram_we}, {28'h0, v.we ? v.be : 4'h0});
      if (v.we) chk("ram_wdata", o.ram_wdata, v.wdata);
    end
    if (is_io && o.req_cnt > 0) begin
      chk("io_addr", {16'h0, o.io_addr}, {16'h0, v.addr[15:0]});
      chk("io_we", {31'h0, o.io_we}, {31'h0, v.we});
      chk("io_be", {28'h0, o.io_be}, {28'h0, v.be});
      chk("io fields stable", o.io_unstable, 0);
      if (v.we) chk("io_wdata", o.io_wdata, v.wdata);
    end
    if (is_ram && v.we) begin
      logic [31:0] w = ram_read(int'(v.addr >> 2));
      for (int b = 0; b < 4; b++) if (v.be[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
      ram_model[int'(v.addr >> 2)] = w;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [13];
    vec_t v;
    obs_t o;
    int   first_rv, rv_cnt, en_cnt, rdy_hi;
    logic [31:0] b_rd;

    vec[0]  = mk(32'h0000_0040, 1, 4'hF, 32'h1234_5678, 0, 0, 2, 0, 32'h0);
    vec[1]  = mk(32'h0000_0040, 0, 4'hF, 32'h0,         0, 0, 2, 0, 32'h1234_5678);
    vec[2]  = mk(32'h0000_0044, 1, 4'h5, 32'hAABB_CCDD, 0, 0, 2, 0, 32'h0);
    vec[3]  = mk(32'h0000_0046, 0, 4'h0, 32'h0,         0, 0, 2, 0, 32'h00BB_00DD);
    vec[4]  = mk(32'h0000_0048, 1, 4'h0, 32'hFFFF_FFFF, 0, 0, 2, 0, 32'h0);
    vec[5]  = mk(32'h0000_0048, 0, 4'hF, 32'h0,         0, 0, 2, 0, 32'h0);
    vec[6]  = mk(32'h1FAF_F020, 0, 4'hF, 32'h0,         3, 32'hA5A5_0001, 4, 0, 32'hA5A5_0001);
    vec[7]  = mk(32'h1FAF_0004, 1, 4'h3, 32'hCAFE_0001, 1, 32'h7777_7777, 2, 0, 32'h0);
    vec[8]  = mk(32'h1FAF_0100, 0, 4'hF, 32'h0,         0, 32'h5555_5555, 5, 1, 32'h0);
    vec[9]  = mk(32'h1FAF_0200, 0, 4'hF, 32'h0,         4, 32'h0000_0012, 5, 0, 32'h0000_0012);
    vec[10] = mk(32'h2000_0000, 0, 4'hF, 32'h0,         0, 0, 1, 1, 32'h0);
    vec[11] = mk(32'h0004_0000, 1, 4'hF, 32'h1111_2222, 0, 0, 1, 1, 32'h0);
    vec[12] = mk(32'h0003_FFFC, 0, 4'hF, 32'h0,         0, 0, 2, 0, 32'h0);

    rst = 1'b1; mem_clr = 1'b1; late_ack = 1'b0; ack_at = 0; io_val = 0;
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset cpu_ready", {31'h0, cpu_ready}, 32'h0);
    chk("reset outputs", {cpu_rvalid, cpu_err, ram_en, io_req, |ram_we, |cpu_rdata}, 6'h0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("cpu_ready after reset", {31'h0, cpu_ready}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      cur_txn = i;
      run_txn(vec[i], o);
      check_txn(vec[i], o);
    end

    // Timeout followed by an ack arriving after the response
    cur_txn = 100;
    v = model(mk(32'h1FAF_0300, 0, 4'hF, 32'h0, 0, 32'h9999_9999, 0, 0, 0));
    run_txn(v, o);
    check_txn(v, o);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("late ack no rvalid", {31'h0, cpu_rvalid}, 32'h0);
    chk("late ack ready", {31'h0, cpu_ready}, 32'h1);
    @(negedge clk);
    chk("late ack no rvalid 2", {31'h0, cpu_rvalid}, 32'h0);

    // RAM_LAT = 3 with cpu_req held high through the transaction
    cur_txn = 200;
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_be = 4'hF; b_addr = 32'h0000_0080; b_wdata = 32'h0;
    @(posedge clk);
    first_rv = 0; rv_cnt = 0; en_cnt = 0; rdy_hi = 0; b_rd = 32'h0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) chk("b ram_en first cycle", {31'h0, b_ram_en}, 32'h1);
      if (b_ram_en) begin
        en_cnt++;
        chk("b ram_we read", {28'h0, b_ram_we}, 32'h0);
      end
      if (n <= 4 && b_ready) rdy_hi++;
      if (b_rvalid) begin
        rv_cnt++;
        if (first_rv == 0) begin
          first_rv = n; b_rd = b_rdata;
          chk("b err", {31'h0, b_err}, 32'h0);
        end
      end
      if (n == 5) b_req = 1'b0;
    end
    chk("b ram_en cycles", en_cnt, 1);
    chk("b rvalid latency", first_rv, 4);
    chk("b single accept", rv_cnt, 1);
    chk("b ready low while busy", rdy_hi, 0);
    chk("b rdata", b_rd, 32'hB0B0_0020);
    chk("b ram_wdata", b_ram_wdata, 32'h0);
    chk("b io idle", {31'h0, b_io_req | b_io_we | (|b_io_be) | (|b_io_addr) | (|b_io_wdata)},
        32'h0);

    // Reset in the middle of an MMIO wait
    cur_txn = 300;
    ack_at = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h1FAF_0010;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("io_req before reset", {31'h0, io_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("io_req dropped by reset", {31'h0, io_req}, 32'h0);
    chk("ready low in reset", {31'h0, cpu_ready}, 32'h0);
    chk("no rvalid in reset", {31'h0, cpu_rvalid}, 32'h0);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) chk("ready after reset release", {31'h0, cpu_ready}, 32'h1);
      chk("no rvalid after abandon", {31'h0, cpu_rvalid}, 32'h0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int kind = $urandom_range(0, 2);
      cur_txn = 1000 + i;
      if (kind == 0) a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      else if (kind == 1) a = {16'h1FAF, 16'($urandom)};
      else a = $urandom | 32'h4000_0000;
      v = mk(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 6), $urandom, 0, 0, 0);
      v = model(v);
      run_txn(v, o);
      check_txn(v, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
